alias_window_reg: RTL

Parametrised multi-channel register bank that exposes each WIDTH-bit channel through two overlapping write windows: a low window at bits [WIN-1:0] and a high window at bits [WIDTH-1:WIDTH-WIN]. It generalises fixed overlapping-alias bus views and single-bit DFF wrapper cells into a clocked, handshaked storage block. Same-cycle overlap conflicts are arbitrated deterministically. An optional shadow/commit stage updates all channels atomically. The block sits between configuration masters and the datapath that consumes the live register values.

---
 rtl/alias_window_pkg.sv | 19 +
 rtl/alias_window_lane.sv | 64 ++++++
 rtl/alias_window_reg.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alias_window_pkg.sv
// Shared types and elaboration helpers for the alias_window_reg bank.
// The commit FSM enum only matters when SHADOW_COMMIT_EN is defined.
package alias_window_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGED = 2'd1,
    COMMIT = 2'd2
  } aw_state_e;

  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int ov_width(input int width, input int win);
    return 2 * win - width;
  endfunction

endpackage

// File: rtl/alias_window_lane.sv
// One channel: merges the low (A) and high (B) window writes into the stored word.
// With SHADOW_COMMIT_EN the merge targets a stage register that is copied to live on load.
module alias_window_lane
  import alias_window_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int WIN       = 12,
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_we,
  input  logic             b_we,
  input  logic [WIN-1:0]   a_data,
  input  logic [WIN-1:0]   b_data,
`ifdef SHADOW_COMMIT_EN
  input  logic             load,
`endif
  output logic [WIDTH-1:0] live
);

  logic [WIDTH-1:0] live_q;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] merged_d;

`ifdef SHADOW_COMMIT_EN
  logic [WIDTH-1:0] stage_q;
  assign base = stage_q;
`else
  assign base = live_q;
`endif

  // The port applied last owns the overlap bits.
  always_comb begin
    merged_d = base;
    if (PRIO_HIGH) begin
      if (a_we) merged_d[WIN-1:0]         = a_data;
      if (b_we) merged_d[WIDTH-1 -: WIN]  = b_data;
    end else begin
      if (b_we) merged_d[WIDTH-1 -: WIN]  = b_data;
      if (a_we) merged_d[WIN-1:0]         = a_data;
    end
  end

`ifdef SHADOW_COMMIT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
      live_q  <= '0;
    end else begin
      stage_q <= merged_d;
      if (load) live_q <= stage_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) live_q <= '0;
    else        live_q <= merged_d;
  end
`endif

  assign live = live_q;

endmodule

// File: rtl/alias_window_reg.sv
// Multi-channel register bank with overlapping low/high write windows per channel.
// Optional SHADOW_COMMIT_EN: writes are staged and applied to q atomically on commit.
//
// state  | meaning
// IDLE   | nothing staged since last commit
// STAGED | at least one write staged, waiting for commit
// COMMIT | one cycle, ports stalled; live <- stage at exit edge
module alias_window_reg
  import alias_window_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int WIN       = 12,
  parameter int NCH       = 4,
  parameter bit PRIO_HIGH = 1'b1,
  localparam int CHW      = chw(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [CHW-1:0]       a_ch,
  input  logic [WIN-1:0]       a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [CHW-1:0]       b_ch,
  input  logic [WIN-1:0]       b_data,
`ifdef SHADOW_COMMIT_EN
  input  logic                 commit,
  output logic                 commit_done,
  output logic                 pending,
`endif
  output logic [NCH*WIDTH-1:0] q,
  output logic [NCH*WIN-1:0]   q_low,
  output logic [NCH*WIN-1:0]   q_high,
  output logic                 conflict
);

  localparam int           OV    = ov_width(WIDTH, WIN);
  localparam logic [CHW:0] NCH_W = NCH[CHW:0];

  logic ready_q;
  logic conflict_q;
  logic conflict_d;
  logic a_acc, b_acc;

  assign a_acc = a_valid & ready_q;
  assign b_acc = b_valid & ready_q;

  // Out-of-range channels are accepted but match no lane.
  assign conflict_d = a_acc & b_acc & (a_ch == b_ch) & ({1'b0, a_ch} < NCH_W) & (OV > 0);

`ifdef SHADOW_COMMIT_EN
  aw_state_e state_q;
  logic      commit_done_q;
  logic      pending_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      conflict_q    <= 1'b0;
      commit_done_q <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      conflict_q    <= conflict_d;
      commit_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (commit) begin
            state_q   <= COMMIT;
            ready_q   <= 1'b0;
            pending_q <= 1'b1;
          end else if (a_acc || b_acc) begin
            state_q   <= STAGED;
            ready_q   <= 1'b1;
            pending_q <= 1'b1;
          end else begin
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        STAGED: begin
          pending_q <= 1'b1;
          if (commit) begin
            state_q <= COMMIT;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        COMMIT: begin
          state_q       <= IDLE;
          ready_q       <= 1'b1;
          pending_q     <= 1'b0;
          commit_done_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          ready_q   <= 1'b1;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign commit_done = commit_done_q;
  assign pending     = pending_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      conflict_q <= conflict_d;
    end
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    alias_window_lane #(
      .WIDTH     (WIDTH),
      .WIN       (WIN),
      .PRIO_HIGH (PRIO_HIGH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_we   (a_acc && (a_ch == CHW'(i))),
      .b_we   (b_acc && (b_ch == CHW'(i))),
      .a_data (a_data),
      .b_data (b_data),
`ifdef SHADOW_COMMIT_EN
      .load   (state_q == COMMIT),
`endif
      .live   (q[i*WIDTH +: WIDTH])
    );

    assign q_low[i*WIN +: WIN]  = q[i*WIDTH +: WIN];
    assign q_high[i*WIN +: WIN] = q[i*WIDTH + WIDTH - WIN +: WIN];
  end

  assign a_ready  = ready_q;
  assign b_ready  = ready_q;
  assign conflict = conflict_q;

endmodule
